// File: rtl/dsel_loc_mch_buf_if.sv
// dsel_loc_mch_buf_if: bundle of the multi-channel dsel write streams and the arbitrated output
interface dsel_loc_mch_buf_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 32,
  parameter int AW     = 32
);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0]    dsel_in_en;
  logic [NUM_CH*AW-1:0] dsel_in_addr;
  logic [NUM_CH*DW-1:0] dsel_in;
  logic [NUM_CH-1:0]    dsel_in_full;
  logic [NUM_CH-1:0]    dsel_ovf;
  logic [NUM_CH-1:0]    dsel_ovf_clr;
  logic                 dsel_out_en;
  logic [AW-1:0]        dsel_out_addr;
  logic [DW-1:0]        dsel_out;
  logic [CHW-1:0]       dsel_out_ch;
  logic                 dsel_out_ready;
  modport master (
    output dsel_in_en, dsel_in_addr, dsel_in, dsel_ovf_clr, dsel_out_ready,
    input  dsel_in_full, dsel_ovf, dsel_out_en, dsel_out_addr, dsel_out, dsel_out_ch
  );
  modport slave (
    input  dsel_in_en, dsel_in_addr, dsel_in, dsel_ovf_clr, dsel_out_ready,
    output dsel_in_full, dsel_ovf, dsel_out_en, dsel_out_addr, dsel_out, dsel_out_ch
  );
endinterface

// File: rtl/dsel_loc_mch_buf.sv
// dsel_loc_mch_buf: per-channel dsel FIFOs round-robin arbitrated onto one registered output
module dsel_loc_mch_buf #(
  parameter int NUM_CH = 4,
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic reset_n,
  dsel_loc_mch_buf_if.slave bus
);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = AW + DW;

  logic [EW-1:0]     mem_q [NUM_CH][DEPTH];
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [PW-1:0]     wp_q  [NUM_CH];
  logic [PW-1:0]     rp_q  [NUM_CH];
  logic [CHW-1:0]    ptr_q, grant_d, ch_q;
  logic              found_d, load_d, en_q;
  logic [NUM_CH-1:0] ne_d, pop_d, wr_d, drop_d, ovf_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     data_q;

  function automatic logic [CHW-1:0] wrap(input logic [CHW:0] s);
    return s >= (CHW+1)'(NUM_CH) ? CHW'(s - (CHW+1)'(NUM_CH)) : CHW'(s);
  endfunction

  // Round-robin grant from ptr, then per-channel pop/accept/drop decisions
  always_comb begin
    load_d  = !en_q || bus.dsel_out_ready;
    grant_d = '0;
    found_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) ne_d[i] = cnt_q[i] != '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (ne_d[wrap({1'b0, ptr_q} + (CHW+1)'(k))]) begin
        grant_d = wrap({1'b0, ptr_q} + (CHW+1)'(k));
        found_d = 1'b1;
      end
    for (int i = 0; i < NUM_CH; i++) begin
      pop_d[i]            = load_d && found_d && grant_d == CHW'(i);
      wr_d[i]             = bus.dsel_in_en[i] && (cnt_q[i] != CW'(DEPTH) || pop_d[i]);
      drop_d[i]           = bus.dsel_in_en[i] && !wr_d[i];
      bus.dsel_in_full[i] = cnt_q[i] == CW'(DEPTH);
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_d[i]) wp_q[i] <= wp_q[i] + PW'(1);
        if (pop_d[i]) rp_q[i] <= rp_q[i] + PW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(wr_d[i]) - CW'(pop_d[i]);
      end
      ovf_q <= (ovf_q & ~bus.dsel_ovf_clr) | drop_d;
    end

  // FIFO storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (wr_d[i]) mem_q[i][wp_q[i]] <= {bus.dsel_in_addr[i*AW +: AW], bus.dsel_in[i*DW +: DW]};

  // Output register: refills when idle or accepted, advancing ptr past the granted channel
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= '0;
    end else if (load_d) begin
      en_q <= found_d;
      if (found_d) begin
        {addr_q, data_q} <= mem_q[grant_d][rp_q[grant_d]];
        ch_q             <= grant_d;
        ptr_q            <= grant_d == CHW'(NUM_CH - 1) ? '0 : grant_d + CHW'(1);
      end
    end

  assign bus.dsel_ovf      = ovf_q;
  assign bus.dsel_out_en   = en_q;
  assign bus.dsel_out_addr = addr_q;
  assign bus.dsel_out      = data_q;
  assign bus.dsel_out_ch   = ch_q;
endmodule

// File: tb/tb_dsel_loc_mch_buf.sv
// tb_dsel_loc_mch_buf: directed stimulus with a scoreboard queue checked by an output monitor
module tb_dsel_loc_mch_buf;
  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  dsel_loc_mch_buf_if #(.NUM_CH(4), .DW(32), .AW(32)) bus ();
  dsel_loc_mch_buf #(.NUM_CH(4), .DW(32), .AW(32), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid and ready are both high
  always @(negedge clk)
    if (reset_n && bus.dsel_out_en && bus.dsel_out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got ch %0d addr %0h data %0h, nothing expected",
                 bus.dsel_out_ch, bus.dsel_out_addr, bus.dsel_out);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.dsel_out_ch, bus.dsel_out_addr, bus.dsel_out} !== mon_e) begin
          fails++;
          $display("FAIL transfer: got ch %0d addr %0h data %0h expected ch %0d addr %0h data %0h",
                   bus.dsel_out_ch, bus.dsel_out_addr, bus.dsel_out, mon_e.ch, mon_e.a, mon_e.d);
        end
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [31:0] a, input logic [31:0] d);
    bus.dsel_in_en[ch]           = 1'b1;
    bus.dsel_in_addr[ch*32 +: 32] = a;
    bus.dsel_in[ch*32 +: 32]      = d;
  endtask

  task automatic clr();
    bus.dsel_in_en = '0;
  endtask

  task automatic expect_out(input int ch, input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{ch: 2'(ch), a: a, d: d});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.dsel_in_en     = '0;
    bus.dsel_in_addr   = '0;
    bus.dsel_in        = '0;
    bus.dsel_ovf_clr   = '0;
    bus.dsel_out_ready = 1'b1;
    #2;
    chk("rst_en", bus.dsel_out_en, 0);
    chk("rst_addr", bus.dsel_out_addr, 0);
    chk("rst_data", bus.dsel_out, 0);
    chk("rst_ch", bus.dsel_out_ch, 0);
    chk("rst_full", bus.dsel_in_full, 0);
    chk("rst_ovf", bus.dsel_ovf, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Single write latency: valid after E+1, for exactly one cycle
    wr(2, 32'h100, 32'hA5A5_0001);
    expect_out(2, 32'h100, 32'hA5A5_0001);
    tick();
    clr();
    chk("t1_not_yet", bus.dsel_out_en, 0);
    tick();
    chk("t1_valid", bus.dsel_out_en, 1);
    chk("t1_ch", bus.dsel_out_ch, 2);
    chk("t1_addr", bus.dsel_out_addr, 32'h100);
    tick();
    chk("t1_one_cycle", bus.dsel_out_en, 0);

    // Round-robin fairness from ptr=0, back-to-back
    do_reset();
    for (int idx = 0; idx < 2; idx++) begin
      for (int c = 0; c < 4; c++) wr(c, 32'h200 + c*16 + idx, c*16 + idx);
      tick();
    end
    clr();
    for (int idx = 0; idx < 2; idx++)
      for (int c = 0; c < 4; c++) expect_out(c, 32'h200 + c*16 + idx, c*16 + idx);
    for (int k = 0; k < 8; k++) begin
      chk("t2_b2b", bus.dsel_out_en, 1);
      tick();
    end
    chk("t2_idle", bus.dsel_out_en, 0);
    chk("t2_drain", sb.size(), 0);

    // Backpressure: stage + 4 FIFO entries, 6th write dropped
    bus.dsel_out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wr(1, 32'h300 + j, 32'hB0 + j);
      expect_out(1, 32'h300 + j, 32'hB0 + j);
      tick();
    end
    clr();
    chk("t3_full", bus.dsel_in_full[1], 1);
    chk("t3_hold_en", bus.dsel_out_en, 1);
    chk("t3_hold_data", bus.dsel_out, 32'hB0);
    wr(1, 32'h305, 32'hB5);
    tick();
    clr();
    chk("t3_ovf", bus.dsel_ovf, 4'b0010);
    chk("t3_hold_data2", bus.dsel_out, 32'hB0);
    chk("t3_hold_ch", bus.dsel_out_ch, 1);
    bus.dsel_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("t3_drain", sb.size(), 0);
    chk("t3_idle", bus.dsel_out_en, 0);
    chk("t3_ovf_sticky", bus.dsel_ovf[1], 1);
    chk("t3_not_full", bus.dsel_in_full[1], 0);
    bus.dsel_ovf_clr[1] = 1'b1;
    tick();
    bus.dsel_ovf_clr = '0;
    chk("t3_ovf_clr", bus.dsel_ovf, 0);

    // Full channel written on the same edge it is popped
    bus.dsel_out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wr(0, 32'h400 + j, 32'hC0 + j);
      expect_out(0, 32'h400 + j, 32'hC0 + j);
      tick();
    end
    clr();
    chk("t4_full", bus.dsel_in_full[0], 1);
    bus.dsel_out_ready = 1'b1;
    wr(0, 32'h405, 32'hC5);
    expect_out(0, 32'h405, 32'hC5);
    tick();
    clr();
    chk("t4_full_hold", bus.dsel_in_full[0], 1);
    chk("t4_no_ovf", bus.dsel_ovf[0], 0);
    for (int k = 0; k < 6; k++) tick();
    chk("t4_drain", sb.size(), 0);
    chk("t4_empty", bus.dsel_in_full[0], 0);

    // Reset mid-stream
    bus.dsel_out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wr(3, 32'h500 + j, 32'hD0 + j);
      tick();
    end
    clr();
    chk("t5_pre_en", bus.dsel_out_en, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_en", bus.dsel_out_en, 0);
    chk("t5_async_data", bus.dsel_out, 0);
    chk("t5_async_ch", bus.dsel_out_ch, 0);
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    bus.dsel_out_ready = 1'b1;
    tick();
    tick();
    chk("t5_no_output", bus.dsel_out_en, 0);
    wr(3, 32'h5E3, 32'hE3);
    wr(1, 32'h5E1, 32'hE1);
    expect_out(1, 32'h5E1, 32'hE1);
    expect_out(3, 32'h5E3, 32'hE3);
    tick();
    clr();
    tick();
    chk("t5_first_grant", bus.dsel_out_ch, 1);
    tick();
    tick();
    chk("t5_drain", sb.size(), 0);

    // Pointer wrap: 12 sequential values through ch0
    for (int j = 1; j <= 12; j++) begin
      wr(0, 32'h600 + j, j);
      expect_out(0, 32'h600 + j, j);
      tick();
      chk("t6_no_full_ovf", {bus.dsel_in_full[0], bus.dsel_ovf[0]}, 0);
    end
    clr();
    for (int k = 0; k < 4; k++) tick();
    chk("t6_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
